// File: rtl/riscv_pkg.sv
// Shared widths and writeback-source encoding for the regfile write-port arbiter.
package riscv_pkg;
   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int LQ_DEPTH = 2;

   // Which source owns the regfile write port this cycle
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LQ   = 2'd2,
      WB_LSU  = 2'd3
   } wb_sel_e;
endpackage

// File: rtl/riscv_wb_fifo.sv
// Small synchronous FIFO with valid/ready on both sides and an occupancy count.
// Used as the load queue: parks load data the write port could not take.
module riscv_wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign do_push   = in_valid && in_ready;
   assign do_pop    = out_valid && out_ready;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_data;
   end
endmodule

// File: rtl/riscv_wb_arbiter.sv
// Regfile write-port owner: arbitrates ALU vs load return, buffers loads that
// lose in a small queue, tracks outstanding loads per register and forwards
// the write in flight to both read ports.
module riscv_wb_arbiter
   import riscv_pkg::*;
#(
   parameter int XLEN     = riscv_pkg::XLEN,
   parameter int REG_AW   = riscv_pkg::REG_AW,
   parameter int LQ_DEPTH = riscv_pkg::LQ_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alu_valid_i,
   input  logic [REG_AW-1:0]         alu_rd_i,
   input  logic [XLEN-1:0]           alu_data_i,
   output logic                      alu_ready_o,
   input  logic                      lsu_valid_i,
   input  logic [REG_AW-1:0]         lsu_rd_i,
   input  logic [XLEN-1:0]           lsu_data_i,
   output logic                      lsu_ready_o,
   input  logic                      ld_issue_i,
   input  logic [REG_AW-1:0]         ld_issue_rd_i,
   input  logic [REG_AW-1:0]         ra0_i,
   input  logic [REG_AW-1:0]         rb0_i,
   output logic                      ra_busy_o,
   output logic                      rb_busy_o,
   output logic                      ra_fwd_o,
   output logic                      rb_fwd_o,
   output logic [XLEN-1:0]           fwd_data_o,
   output logic                      rf_wen_o,
   output logic [REG_AW-1:0]         rf_rd_o,
   output logic [XLEN-1:0]           rf_wdata_o,
   output logic [$clog2(LQ_DEPTH):0] lq_count_o
);
   localparam int NREG = 2 ** REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } lq_ent_t;

   wb_sel_e           sel;
   lq_ent_t           lq_in, lq_head;
   logic              lq_in_ready, lq_nempty, lq_full;
   logic              lq_push, lq_pop;
   logic [REG_AW-1:0] win_rd;
   logic [XLEN-1:0]   win_data;
   logic              ld_win;
   logic [NREG-1:0]   sb, sb_nxt;

   assign lq_full     = !lq_in_ready;
   assign alu_ready_o = !reset && !lq_full;
   assign lsu_ready_o = !reset && !lq_full;

   // Fixed-priority pick: a full queue must drain first, then ALU, then queued loads, then a direct load
   always_comb begin
      sel = WB_NONE;
      if (!reset) begin
         if (lq_full)          sel = WB_LQ;
         else if (alu_valid_i) sel = WB_ALU;
         else if (lq_nempty)   sel = WB_LQ;
         else if (lsu_valid_i) sel = WB_LSU;
      end
   end

   // Winning destination/data; idle cycles load zeros
   always_comb begin
      win_rd   = '0;
      win_data = '0;
      unique case (sel)
         WB_ALU:  begin win_rd = alu_rd_i;   win_data = alu_data_i;   end
         WB_LQ:   begin win_rd = lq_head.rd; win_data = lq_head.data; end
         WB_LSU:  begin win_rd = lsu_rd_i;   win_data = lsu_data_i;   end
         default: ;
      endcase
   end

   assign ld_win  = (sel == WB_LQ) || (sel == WB_LSU);
   assign lq_pop  = (sel == WB_LQ);
   assign lq_push = lsu_valid_i && lsu_ready_o && (sel != WB_LSU);
   assign lq_in   = '{rd: lsu_rd_i, data: lsu_data_i};

   riscv_wb_fifo #(
      .W     ($bits(lq_ent_t)),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (lq_push),
      .in_ready  (lq_in_ready),
      .in_data   (lq_in),
      .out_valid (lq_nempty),
      .out_ready (lq_pop),
      .out_data  (lq_head),
      .count     (lq_count_o)
   );

   // WB register: winner drives the regfile port next cycle; x0 writes are swallowed
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wen_o   <= 1'b0;
         rf_rd_o    <= '0;
         rf_wdata_o <= '0;
      end else begin
         rf_wen_o   <= (sel != WB_NONE) && (win_rd != '0);
         rf_rd_o    <= win_rd;
         rf_wdata_o <= win_data;
      end
   end

   // Scoreboard update: clear on load writeback, then set on issue so a same-rd set wins
   always_comb begin
      sb_nxt = sb;
      if (ld_win) sb_nxt[win_rd] = 1'b0;
      if (ld_issue_i && ld_issue_rd_i != '0) sb_nxt[ld_issue_rd_i] = 1'b1;
      sb_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (reset) sb <= '0;
      else       sb <= sb_nxt;
   end

   assign ra_busy_o  = !reset && sb[ra0_i];
   assign rb_busy_o  = !reset && sb[rb0_i];
   assign ra_fwd_o   = !reset && rf_wen_o && (rf_rd_o == ra0_i) && (ra0_i != '0);
   assign rb_fwd_o   = !reset && rf_wen_o && (rf_rd_o == rb0_i) && (rb0_i != '0);
   assign fwd_data_o = rf_wdata_o;

   // Protocol checks on the surrounding pipeline; these cases are not handled by the logic
   a_issue_busy: assert property (@(posedge clk) disable iff (reset)
      (ld_issue_i && ld_issue_rd_i != '0) |-> (!sb[ld_issue_rd_i] || (ld_win && win_rd == ld_issue_rd_i)));
   a_alu_busy: assert property (@(posedge clk) disable iff (reset)
      (alu_valid_i && alu_ready_o && alu_rd_i != '0) |-> !sb[alu_rd_i]);
   a_lsu_unissued: assert property (@(posedge clk) disable iff (reset)
      (lsu_valid_i && lsu_rd_i != '0) |-> sb[lsu_rd_i]);
endmodule
